// File: rtl/fifo_ctrl_pkg.sv
// Shared constants and helpers for the FIFO producer arbiter.
package fifo_ctrl_pkg;

    localparam int default_num_req = 4;
    localparam int default_bits    = 16;
    localparam int default_depth   = 8;

    // Smallest r with 2**r >= value; clog2(depth+1) sizes the occupancy count.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Width of a producer index; never zero so single-producer builds still elaborate.
    function automatic int index_width(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_pick
    import fifo_ctrl_pkg::*;
#(
    parameter int num_req = default_num_req,
    parameter int pw      = index_width(default_num_req)
) (
    input  logic [num_req-1:0] req,
    input  logic [pw-1:0]      ptr,
    input  logic               enable,
    output logic [num_req-1:0] gnt,
    output logic [pw-1:0]      idx,
    output logic               valid
);

    // Scan candidates ptr, ptr+1, ... modulo num_req and take the first requester.
    always_comb begin
        int s;
        logic [pw-1:0] cand;
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        s     = 0;
        cand  = '0;
        for (int k = 0; k < num_req; k++) begin
            s = int'(ptr) + k;
            if (s >= num_req) begin
                s = s - num_req;
            end
            cand = pw'(s);
            if (enable && !valid && req[cand]) begin
                gnt[cand] = 1'b1;
                idx       = cand;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter feeding one fifo_flops instance from several producers.
// count tracks entries committed (in the FIFO plus the registered push in flight),
// so grants stop before the FIFO can ever be pushed while full.
module fifo_rr_arbiter
    import fifo_ctrl_pkg::*;
#(
    parameter int num_req = default_num_req,
    parameter int bits    = default_bits,
    parameter int depth   = default_depth
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [num_req-1:0]            req,
    input  logic [num_req*bits-1:0]       din_req,
    output logic [num_req-1:0]            gnt,
    input  logic                          pop,
    input  logic                          pndng,
    input  logic                          full,
    output logic                          push,
    output logic [bits-1:0]               Din,
    output logic [clog2(depth+1)-1:0]     count,
    output logic                          err
);

    localparam int cw = clog2(depth + 1);
    localparam int pw = index_width(num_req);

    logic [pw-1:0]   ptr_reg;
    logic [pw-1:0]   ptr_next;
    logic [cw-1:0]   count_reg;
    logic [cw-1:0]   count_next;
    logic            push_reg;
    logic [bits-1:0] din_reg;
    logic            err_reg;

    logic            can_grant;
    logic            valid_pop;
    logic            pick_valid;
    logic [pw-1:0]   pick_idx;
    logic [bits-1:0] din_arr [num_req];

    // Unpack the flat producer data bus into one word per producer.
    generate
        for (genvar gi = 0; gi < num_req; gi++) begin : g_unpack
            assign din_arr[gi] = din_req[gi*bits +: bits];
        end
    endgenerate

    // Gating on rst keeps gnt low while reset is held.
    assign can_grant = rst && (count_reg < cw'(depth));
    assign valid_pop = pop && pndng;

    rr_pick #(
        .num_req (num_req),
        .pw      (pw)
    ) u_pick (
        .req     (req),
        .ptr     (ptr_reg),
        .enable  (can_grant),
        .gnt     (gnt),
        .idx     (pick_idx),
        .valid   (pick_valid)
    );

    // Next pointer and committed-entry count from this cycle's grant and pop.
    always_comb begin
        ptr_next   = ptr_reg;
        count_next = count_reg;
        if (pick_valid) begin
            ptr_next = (int'(pick_idx) == num_req - 1) ? '0 : pick_idx + pw'(1);
        end
        if (pick_valid && !valid_pop) begin
            count_next = count_reg + cw'(1);
        end else if (!pick_valid && valid_pop && (count_reg != '0)) begin
            count_next = count_reg - cw'(1);
        end
    end

    // Arbitration state, registered push/data toward the FIFO, sticky error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_reg   <= '0;
            count_reg <= '0;
            push_reg  <= 1'b0;
            din_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            ptr_reg   <= ptr_next;
            count_reg <= count_next;
            push_reg  <= pick_valid;
            if (pick_valid) begin
                din_reg <= din_arr[pick_idx];
            end
            if ((push_reg && full) || (pop && !pndng)) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign push  = push_reg;
    assign Din   = din_reg;
    assign count = count_reg;
    assign err   = err_reg;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench for fifo_rr_arbiter with a behavioural occupancy stand-in for fifo_flops.
module tb_fifo_rr_arbiter;

    localparam int num_req = 4;
    localparam int bits    = 16;
    localparam int depth   = 8;

    logic                    clk;
    logic                    rst;
    logic [num_req-1:0]      req;
    logic [num_req*bits-1:0] din_req;
    logic [num_req-1:0]      gnt;
    logic                    pop;
    logic                    pndng;
    logic                    full;
    logic                    push;
    logic [bits-1:0]         Din;
    logic [3:0]              count;
    logic                    err;

    logic [bits-1:0] pdata [num_req];
    int              occ;
    int              tests;
    int              fails;

    fifo_rr_arbiter #(
        .num_req (num_req),
        .bits    (bits),
        .depth   (depth)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .din_req (din_req),
        .gnt     (gnt),
        .pop     (pop),
        .pndng   (pndng),
        .full    (full),
        .push    (push),
        .Din     (Din),
        .count   (count),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        din_req = '0;
        for (int i = 0; i < num_req; i++) begin
            din_req[i*bits +: bits] = pdata[i];
        end
    end

    // FIFO occupancy stand-in: pushes land, valid pops leave.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ <= 0;
        end else begin
            occ <= occ + (push ? 1 : 0) - ((pop && occ != 0) ? 1 : 0);
        end
    end
    assign pndng = (occ != 0);
    assign full  = (occ == depth);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests = tests + 1;
        if (got !== exp) begin
            fails = fails + 1;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b0;
        req   = 4'b1111;
        pop   = 1'b0;
        for (int i = 0; i < num_req; i++) pdata[i] = 16'h1000 + 16'(i);

        // Reset state, gnt forced low even with requests pending
        #2;
        check("rst_push", 32'(push), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_din", 32'(Din), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;

        // Fill: all requesting, no pop -> 0,1,2,3,0,1,2,3
        for (int k = 0; k < 8; k++) begin
            check($sformatf("fill_gnt%0d", k), 32'(gnt), 32'(4'b0001 << (k % 4)));
            tick();
            check($sformatf("fill_push%0d", k), 32'(push), 32'd1);
            check($sformatf("fill_din%0d", k), 32'(Din), 32'h1000 + 32'(k % 4));
            check($sformatf("fill_cnt%0d", k), 32'(count), 32'(k + 1));
        end
        check("full_gnt", 32'(gnt), 32'd0);
        tick();
        check("full_push", 32'(push), 32'd0);
        check("full_cnt", 32'(count), 32'd8);
        check("full_err", 32'(err), 32'd0);

        // Full, single pop frees one slot for producer 2
        req = 4'b0100;
        pop = 1'b1;
        #1;
        check("pop_gnt0", 32'(gnt), 32'd0);
        tick();
        pop = 1'b0;
        check("pop_cnt", 32'(count), 32'd7);
        check("pop_gnt1", 32'(gnt), 32'b0100);
        tick();
        check("pop_cnt8", 32'(count), 32'd8);
        check("pop_push", 32'(push), 32'd1);
        check("pop_din", 32'(Din), 32'h1002);
        req = 4'b0000;
        tick();
        check("pop_push0", 32'(push), 32'd0);

        // Drain to 3, then grant and valid pop together (ptr=3 wraps to 0)
        pop = 1'b1;
        repeat (5) tick();
        check("drain_cnt", 32'(count), 32'd3);
        pdata[0] = 16'hA5A5;
        req = 4'b0001;
        #1;
        check("same_gnt", 32'(gnt), 32'b0001);
        tick();
        check("same_cnt", 32'(count), 32'd3);
        check("same_push", 32'(push), 32'd1);
        check("same_din", 32'(Din), 32'hA5A5);
        pop = 1'b0;
        req = 4'b0010;
        #1;

        // Move ptr to 2, then wrap with req=0011
        check("rr_gnt1", 32'(gnt), 32'b0010);
        tick();
        check("rr_cnt4", 32'(count), 32'd4);
        req = 4'b0011;
        #1;
        check("wrap_gnt", 32'(gnt), 32'b0001);
        tick();
        check("wrap_next", 32'(gnt), 32'b0010);
        tick();
        check("wrap_din", 32'(Din), 32'h1001);
        check("wrap_cnt", 32'(count), 32'd6);
        req = 4'b0000;
        #1;
        check("idle_gnt", 32'(gnt), 32'd0);

        // Async reset mid-burst with push pending
        req = 4'b1111;
        #1;
        check("burst_gnt", 32'(gnt), 32'b0100);
        tick();
        check("burst_push", 32'(push), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_push", 32'(push), 32'd0);
        check("arst_cnt", 32'(count), 32'd0);
        check("arst_err", 32'(err), 32'd0);
        check("arst_gnt", 32'(gnt), 32'd0);
        req = 4'b0000;
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("rel_push0", 32'(push), 32'd0);
        tick();
        check("rel_push1", 32'(push), 32'd0);
        check("rel_cnt", 32'(count), 32'd0);

        // Pop on empty FIFO sets sticky err
        pop = 1'b1;
        tick();
        pop = 1'b0;
        check("uflow_err", 32'(err), 32'd1);
        tick();
        tick();
        check("sticky_err", 32'(err), 32'd1);
        check("uflow_cnt", 32'(count), 32'd0);

        // Pointer restarted at 0 after reset
        req = 4'b1001;
        #1;
        check("ptr0_gnt", 32'(gnt), 32'b0001);
        tick();
        req = 4'b0000;
        check("ptr0_push", 32'(push), 32'd1);
        check("ptr0_din", 32'(Din), 32'hA5A5);
        rst = 1'b0;
        #1;
        check("clr_err", 32'(err), 32'd0);
        rst = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
